blake2s_host_drv: RTL and testbench

- Host-side driver for the BLAKE2s accelerator's byte-serial command interface.
- Accepts a hash job descriptor (kk, nn, ll) and an upstream byte stream. The stream carries the key bytes first, then the message bytes.
- Serialises the job into CONF, START and DATA command beats on valid_o/cmd_o/data_o, zero-padding the key block and the final block to 64 bytes.
- Captures the nn-byte digest returned on hash_v_i/hash_i and forwards it as an indexed result stream. Used in the FPGA/test harness that drives the ASIC pins.

---
 rtl/blake2s_host_pkg.sv | 37 +++
 rtl/blake2s_host_blk_ctr.sv | 64 ++++++
 rtl/blake2s_host_drv.sv | 195 +++++++++++++++++++
 tb/tb_blake2s_host_drv.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2s_host_pkg.sv
// Shared definitions for the BLAKE2s host-side command driver.
package blake2s_host_pkg;

  localparam logic [1:0] CMD_CONF  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_DATA  = 2'd2;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned MAX_KK      = 32;
  localparam int unsigned MAX_NN      = 32;
  localparam int unsigned CONF_BYTES  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONF,
    ST_START,
    ST_DATA,
    ST_GAP,
    ST_WAIT_H,
    ST_RESP
  } state_t;

  // CONF payload: kk, nn, then ll little-endian
  function automatic logic [7:0] conf_byte(input logic [5:0]  kk,
                                           input logic [5:0]  nn,
                                           input logic [63:0] ll,
                                           input logic [3:0]  idx);
    logic [2:0] b;
    b = 3'(idx - 4'd2);
    case (idx)
      4'd0:    return {2'b00, kk};
      4'd1:    return {2'b00, nn};
      default: return ll[{b, 3'b000} +: 8];
    endcase
  endfunction

endpackage

// File: rtl/blake2s_host_blk_ctr.sv
// Tracks owed stream bytes (key, then message) and the byte index within a 64-byte block.
module blake2s_host_blk_ctr
  import blake2s_host_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        load,
  input  logic [5:0]  load_kk,
  input  logic [63:0] load_ll,
  input  logic        beat,
  output logic        byte_is_pad,
  output logic        byte_is_pad_nxt,
  output logic        block_end,
  output logic        last_block
);

  logic        key_phase, key_phase_n;
  logic [5:0]  key_rem, key_rem_n;
  logic [63:0] msg_rem, msg_rem_n;
  logic [5:0]  idx, idx_n;
  logic [6:0]  room;

  always_comb begin
    room        = 7'(BLOCK_BYTES) - {1'b0, idx};
    byte_is_pad = key_phase ? (key_rem == '0) : (msg_rem == '0);
    block_end   = (idx == 6'(BLOCK_BYTES - 1));
    // the key block is final only for an empty message; otherwise final once the rest fits
    last_block  = key_phase ? (msg_rem == '0) : (msg_rem <= {57'd0, room});

    key_phase_n = key_phase;
    key_rem_n   = key_rem;
    msg_rem_n   = msg_rem;
    idx_n       = idx;
    if (load) begin
      key_phase_n = (load_kk != '0);
      key_rem_n   = load_kk;
      msg_rem_n   = load_ll;
      idx_n       = '0;
    end else if (beat) begin
      idx_n = idx + 6'd1;
      if (!byte_is_pad) begin
        if (key_phase) key_rem_n = key_rem - 6'd1;
        else           msg_rem_n = msg_rem - 64'd1;
      end
      if (block_end) key_phase_n = 1'b0;
    end
    byte_is_pad_nxt = key_phase_n ? (key_rem_n == '0) : (msg_rem_n == '0);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      key_phase <= 1'b0;
      key_rem   <= '0;
      msg_rem   <= '0;
      idx       <= '0;
    end else begin
      key_phase <= key_phase_n;
      key_rem   <= key_rem_n;
      msg_rem   <= msg_rem_n;
      idx       <= idx_n;
    end
  end

endmodule

// File: rtl/blake2s_host_drv.sv
// Serialises a BLAKE2s job into CONF/START/DATA beats and forwards the returned digest.
module blake2s_host_drv
  import blake2s_host_pkg::*;
#(
  parameter int unsigned BLOCK_GAP    = 128,
  parameter int unsigned RESP_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        job_v_i,
  output logic        job_ready_o,
  input  logic [5:0]  job_kk_i,
  input  logic [5:0]  job_nn_i,
  input  logic [63:0] job_ll_i,
  input  logic        msg_v_i,
  output logic        msg_ready_o,
  input  logic [7:0]  msg_i,
  output logic        valid_o,
  output logic [1:0]  cmd_o,
  output logic [7:0]  data_o,
  input  logic        hash_v_i,
  input  logic [7:0]  hash_i,
  output logic        res_v_o,
  output logic [7:0]  res_o,
  output logic [4:0]  res_idx_o,
  output logic        res_last_o,
  output logic        err_o,
  output logic        busy_o
);

  state_t      state, state_n;
  logic [5:0]  kk_q, kk_n, nn_q, nn_n;
  logic [63:0] ll_q, ll_n;
  logic [3:0]  conf_idx, conf_idx_n;
  logic [31:0] cyc_cnt, cyc_n;
  logic [4:0]  res_cnt, res_cnt_n;

  logic        valid_n, res_v_n, res_last_n, err_n;
  logic [1:0]  cmd_n;
  logic [7:0]  data_n, res_n;
  logic [4:0]  res_idx_n;

  logic ctr_load, beat;
  logic byte_is_pad, byte_is_pad_nxt, block_end, last_block;

  blake2s_host_blk_ctr u_blk_ctr (
    .clk             (clk),
    .nreset          (nreset),
    .load            (ctr_load),
    .load_kk         (job_kk_i),
    .load_ll         (job_ll_i),
    .beat            (beat),
    .byte_is_pad     (byte_is_pad),
    .byte_is_pad_nxt (byte_is_pad_nxt),
    .block_end       (block_end),
    .last_block      (last_block)
  );

  always_comb begin
    state_n    = state;
    kk_n       = kk_q;
    nn_n       = nn_q;
    ll_n       = ll_q;
    conf_idx_n = conf_idx;
    cyc_n      = cyc_cnt;
    res_cnt_n  = res_cnt;
    valid_n    = 1'b0;
    cmd_n      = CMD_CONF;
    data_n     = '0;
    res_v_n    = 1'b0;
    res_n      = '0;
    res_idx_n  = '0;
    res_last_n = 1'b0;
    err_n      = 1'b0;
    ctr_load   = 1'b0;
    beat       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (job_v_i && job_ready_o) begin
          if (job_kk_i > 6'(MAX_KK) || job_nn_i == '0 || job_nn_i > 6'(MAX_NN)) begin
            err_n = 1'b1;
          end else begin
            kk_n       = job_kk_i;
            nn_n       = job_nn_i;
            ll_n       = job_ll_i;
            ctr_load   = 1'b1;
            conf_idx_n = '0;
            state_n    = ST_CONF;
          end
        end
      end
      ST_CONF: begin
        valid_n = 1'b1;
        cmd_n   = CMD_CONF;
        data_n  = conf_byte(kk_q, nn_q, ll_q, conf_idx);
        if (conf_idx == 4'(CONF_BYTES - 1)) state_n = ST_START;
        else                                conf_idx_n = conf_idx + 4'd1;
      end
      ST_START: begin
        valid_n = 1'b1;
        cmd_n   = CMD_START;
        state_n = ST_DATA;
      end
      ST_DATA: begin
        beat = byte_is_pad || (msg_v_i && msg_ready_o);
        if (beat) begin
          valid_n = 1'b1;
          cmd_n   = CMD_DATA;
          data_n  = byte_is_pad ? 8'h00 : msg_i;
          cyc_n   = '0;
          if (block_end) begin
            if (last_block) begin
              state_n   = ST_WAIT_H;
              res_cnt_n = '0;
            end else if (BLOCK_GAP != 0) begin
              state_n = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (cyc_cnt == BLOCK_GAP - 1) state_n = ST_DATA;
        else                          cyc_n = cyc_cnt + 32'd1;
      end
      ST_WAIT_H, ST_RESP: begin
        // the first digest byte is also the one that ends WAIT_H
        if (hash_v_i) begin
          res_v_n   = 1'b1;
          res_n     = hash_i;
          res_idx_n = res_cnt;
          if ({1'b0, res_cnt} == nn_q - 6'd1) begin
            res_last_n = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            res_cnt_n = res_cnt + 5'd1;
            state_n   = ST_RESP;
          end
        end else if (state == ST_WAIT_H) begin
          if (cyc_cnt == RESP_TIMEOUT - 1) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end else begin
            cyc_n = cyc_cnt + 32'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      kk_q        <= '0;
      nn_q        <= '0;
      ll_q        <= '0;
      conf_idx    <= '0;
      cyc_cnt     <= '0;
      res_cnt     <= '0;
      valid_o     <= 1'b0;
      cmd_o       <= '0;
      data_o      <= '0;
      msg_ready_o <= 1'b0;
      res_v_o     <= 1'b0;
      res_o       <= '0;
      res_idx_o   <= '0;
      res_last_o  <= 1'b0;
      err_o       <= 1'b0;
      job_ready_o <= 1'b1;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_n;
      kk_q        <= kk_n;
      nn_q        <= nn_n;
      ll_q        <= ll_n;
      conf_idx    <= conf_idx_n;
      cyc_cnt     <= cyc_n;
      res_cnt     <= res_cnt_n;
      valid_o     <= valid_n;
      cmd_o       <= cmd_n;
      data_o      <= data_n;
      // ready is registered, so it must reflect the counter after this cycle's beat
      msg_ready_o <= (state_n == ST_DATA) && !byte_is_pad_nxt;
      res_v_o     <= res_v_n;
      res_o       <= res_n;
      res_idx_o   <= res_idx_n;
      res_last_o  <= res_last_n;
      err_o       <= err_n;
      job_ready_o <= (state_n == ST_IDLE);
      busy_o      <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_blake2s_host_drv.sv
// Directed scoreboard bench for blake2s_host_drv: beat and result queues checked by monitors.
module tb_blake2s_host_drv;
  import blake2s_host_pkg::*;

  localparam int unsigned GAP = 16;
  localparam int unsigned TMO = 64;

  logic        clk, nreset;
  logic        job_v_i, job_ready_o;
  logic [5:0]  job_kk_i, job_nn_i;
  logic [63:0] job_ll_i;
  logic        msg_v_i, msg_ready_o;
  logic [7:0]  msg_i;
  logic        valid_o;
  logic [1:0]  cmd_o;
  logic [7:0]  data_o;
  logic        hash_v_i;
  logic [7:0]  hash_i;
  logic        res_v_o, res_last_o, err_o, busy_o;
  logic [7:0]  res_o;
  logic [4:0]  res_idx_o;

  blake2s_host_drv #(.BLOCK_GAP(GAP), .RESP_TIMEOUT(TMO)) dut (
    .clk(clk), .nreset(nreset),
    .job_v_i(job_v_i), .job_ready_o(job_ready_o),
    .job_kk_i(job_kk_i), .job_nn_i(job_nn_i), .job_ll_i(job_ll_i),
    .msg_v_i(msg_v_i), .msg_ready_o(msg_ready_o), .msg_i(msg_i),
    .valid_o(valid_o), .cmd_o(cmd_o), .data_o(data_o),
    .hash_v_i(hash_v_i), .hash_i(hash_i),
    .res_v_o(res_v_o), .res_o(res_o), .res_idx_o(res_idx_o), .res_last_o(res_last_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0]  exp_beats[$];
  logic [13:0] exp_res[$];
  logic [7:0]  stream_q[$];
  int          data_cyc[$];
  int          pad_cnt, err_cnt, err_cyc;
  bit          ready_seen, tog_mode;
  logic [9:0]  be_e;
  logic [13:0] re_e;
  logic [255:0] abc_digest =
    256'h508C5E8C327C14E2E1A72BA34EEB452F37458B209ED63A294D999B4C86675982;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // output monitor: command beats and result bytes against the scoreboard queues
  always @(negedge clk) begin
    if (nreset) begin
      if (msg_ready_o) ready_seen = 1'b1;
      if (err_o) begin err_cnt++; err_cyc = cyc; end
      if (valid_o) begin
        if (exp_beats.size() == 0) chk("beat_extra", valid_o, 1'b0);
        else begin
          be_e = exp_beats.pop_front();
          chk("beat", {cmd_o, data_o}, be_e);
        end
        if (cmd_o == CMD_DATA) begin
          data_cyc.push_back(cyc);
          if (data_o == 8'h00) pad_cnt++;
        end
      end
      if (res_v_o) begin
        if (exp_res.size() == 0) chk("res_extra", res_v_o, 1'b0);
        else begin
          re_e = exp_res.pop_front();
          chk("res", {res_idx_o, res_last_o, res_o}, re_e);
        end
      end
    end
  end

  // upstream byte source; optionally presents a byte only on alternate cycles
  bit fire, phase;
  initial begin
    msg_v_i = 1'b0; msg_i = 8'h00; phase = 1'b0;
    forever begin
      @(negedge clk);
      fire = nreset && msg_v_i && msg_ready_o;
      @(posedge clk);
      #1;
      if (fire && stream_q.size() > 0) void'(stream_q.pop_front());
      phase = ~phase;
      if (stream_q.size() > 0 && (!tog_mode || phase)) begin
        msg_v_i = 1'b1; msg_i = stream_q[0];
      end else begin
        msg_v_i = 1'b0; msg_i = 8'h00;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int kk, input int nn, input longint ll, input bit tog);
    logic [7:0] b;
    int rem, pads;
    tog_mode = tog; data_cyc.delete(); pad_cnt = 0; ready_seen = 1'b0; err_cnt = 0;
    exp_beats.push_back({CMD_CONF, 8'(kk)});
    exp_beats.push_back({CMD_CONF, 8'(nn)});
    for (int i = 0; i < 8; i++) exp_beats.push_back({CMD_CONF, 8'(ll >> (8 * i))});
    exp_beats.push_back({CMD_START, 8'h00});
    for (int i = 0; i < kk; i++) begin
      b = 8'($urandom_range(1, 255));
      stream_q.push_back(b);
      exp_beats.push_back({CMD_DATA, b});
    end
    if (kk > 0) for (int i = kk; i < 64; i++) exp_beats.push_back({CMD_DATA, 8'h00});
    for (longint i = 0; i < ll; i++) begin
      b = 8'h61 + 8'(i % 26);
      stream_q.push_back(b);
      exp_beats.push_back({CMD_DATA, b});
    end
    rem  = int'(ll % 64);
    pads = (ll == 0) ? ((kk == 0) ? 64 : 0) : ((rem == 0) ? 0 : 64 - rem);
    for (int i = 0; i < pads; i++) exp_beats.push_back({CMD_DATA, 8'h00});
    tick();
    job_v_i = 1'b1; job_kk_i = 6'(kk); job_nn_i = 6'(nn); job_ll_i = ll;
    tick();
    job_v_i = 1'b0;
    chk("busy_after_accept", busy_o, 1'b1);
    chk("ready_low_after_accept", job_ready_o, 1'b0);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_beats.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("beats_drained", exp_beats.size(), 0);
    chk("stream_consumed", stream_q.size(), 0);
  endtask

  task automatic respond(input int nn, input bit gaps, input bit abc);
    logic [7:0] b;
    for (int i = 0; i < nn; i++) begin
      b = abc ? 8'(abc_digest >> (8 * (31 - i))) : 8'($urandom_range(0, 255));
      tick();
      hash_v_i = 1'b1; hash_i = b;
      exp_res.push_back({5'(i), (i == nn - 1), b});
      if (gaps && (i % 3 == 1)) begin tick(); hash_v_i = 1'b0; end
    end
    tick();
    hash_v_i = 1'b0;
    tick();
    tick();
    chk("res_drained", exp_res.size(), 0);
    chk("idle_ready", job_ready_o, 1'b1);
    chk("idle_busy", busy_o, 1'b0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk(tag, {valid_o, cmd_o, data_o, msg_ready_o, res_v_o, res_o, res_idx_o,
              res_last_o, err_o, busy_o, job_ready_o}, 35'h1);
  endtask

  initial begin
    nreset = 1'b0; job_v_i = 1'b0; job_kk_i = '0; job_nn_i = '0; job_ll_i = '0;
    hash_v_i = 1'b0; hash_i = '0; tog_mode = 1'b0;
    repeat (3) tick();
    check_reset_outs("reset_state");
    nreset = 1'b1;
    tick();

    // "abc", unkeyed, 32-byte digest
    start_job(0, 32, 3, 1'b0);
    drain(2000);
    chk("t1_data_beats", data_cyc.size(), 64);
    chk("t1_pads", pad_cnt, 61);
    if (data_cyc.size() >= 64) chk("t1_no_gap", data_cyc[63] - data_cyc[0], 63);
    respond(32, 1'b1, 1'b1);

    // empty message: one zero block, stream never requested
    start_job(0, 16, 0, 1'b0);
    drain(2000);
    chk("t2_ready_never", ready_seen, 1'b0);
    chk("t2_pads", pad_cnt, 64);
    respond(16, 1'b0, 1'b0);

    // keyed: key block, GAP, message block
    start_job(32, 32, 64, 1'b0);
    drain(2000);
    chk("t3_data_beats", data_cyc.size(), 128);
    chk("t3_pads", pad_cnt, 32);
    if (data_cyc.size() >= 65) begin
      chk("t3_key_contig", data_cyc[63] - data_cyc[0], 63);
      chk("t3_gap", data_cyc[64] - data_cyc[63], GAP + 1);
    end
    respond(32, 1'b1, 1'b0);

    // 130 bytes with a stalling source
    start_job(0, 8, 130, 1'b1);
    drain(3000);
    chk("t4_data_beats", data_cyc.size(), 192);
    chk("t4_pads", pad_cnt, 62);
    if (data_cyc.size() >= 11) chk("t4_stall_spacing", data_cyc[10] - data_cyc[9], 2);
    respond(8, 1'b1, 1'b0);
    tog_mode = 1'b0;

    // invalid descriptors
    err_cnt = 0;
    tick();
    job_v_i = 1'b1; job_kk_i = 6'd0; job_nn_i = 6'd0; job_ll_i = 64'd5;
    tick();
    job_v_i = 1'b0;
    chk("t5_err_nn0", err_o, 1'b1);
    chk("t5_ready_nn0", job_ready_o, 1'b1);
    chk("t5_busy_nn0", busy_o, 1'b0);
    tick();
    chk("t5_err_pulse_nn0", err_o, 1'b0);
    job_v_i = 1'b1; job_kk_i = 6'd33; job_nn_i = 6'd16; job_ll_i = 64'd5;
    tick();
    job_v_i = 1'b0;
    chk("t5_err_kk33", err_o, 1'b1);
    chk("t5_ready_kk33", job_ready_o, 1'b1);
    tick();
    chk("t5_err_pulse_kk33", err_o, 1'b0);
    repeat (4) tick();
    chk("t5_err_count", err_cnt, 2);

    // response timeout
    start_job(0, 16, 5, 1'b0);
    drain(2000);
    for (int n = 0; n < int'(TMO) + 50 && err_cnt == 0; n++) @(negedge clk);
    chk("t6_timeout_seen", err_cnt, 1);
    if (data_cyc.size() >= 64) chk("t6_timeout_delay", err_cyc - data_cyc[63], TMO);
    tick();
    chk("t6_idle_ready", job_ready_o, 1'b1);
    chk("t6_idle_busy", busy_o, 1'b0);

    // reset in the middle of DATA, then a normal job
    start_job(0, 8, 200, 1'b0);
    for (int n = 0; n < 2000 && data_cyc.size() < 20; n++) @(negedge clk);
    chk("t7_reached_data", data_cyc.size() >= 20, 1'b1);
    @(posedge clk);
    #2 nreset = 1'b0;
    @(posedge clk);
    #2;
    check_reset_outs("t7_reset_outs");
    exp_beats.delete();
    stream_q.delete();
    nreset = 1'b1;
    repeat (5) tick();
    chk("t7_quiet_after_reset", busy_o, 1'b0);
    start_job(0, 32, 3, 1'b0);
    drain(2000);
    chk("t7_data_beats", data_cyc.size(), 64);
    respond(32, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
